// File: rtl/alu_multicycle.sv
// alu_multicycle: registered single-cycle ALU plus iterative MULT/DIV unit with HI/LO registers.
// Build option: define ALU_SIGNED_MD_EN for two's-complement signed MULT/DIV (unsigned otherwise).
module alu_multicycle #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         ALUOperation,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [SHAMT_W-1:0] Shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   ALUResult,
   output logic               Zero,
   output logic               div_by_zero,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOR  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_MFHI = 4'b0101;
   localparam logic [3:0] OP_MFLO = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_JR   = 4'b1011;
   localparam logic [3:0] OP_BEQ  = 4'b1100;
   localparam logic [3:0] OP_MULT = 4'b1101;
   localparam logic [3:0] OP_LUI  = 4'b1110;
   localparam logic [3:0] OP_DIV  = 4'b1111;

   localparam logic [SHAMT_W:0] CNT_INIT = (SHAMT_W+1)'(WIDTH);
   localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

   state_t               state_r, state_s;
   logic [SHAMT_W:0]     cnt_r;
   logic [WIDTH-1:0]     mcand_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic                 bz_r;
   logic                 accept_s, last_s;
   logic [WIDTH-1:0]     res_s, a_mag_s, b_mag_s;
   logic [WIDTH-1:0]     fin_hi_s, fin_lo_s, fin_q_s;
   logic [WIDTH:0]       mul_sum_s, div_shift_s;
   logic [WIDTH-1:0]     div_sub_s;
   logic                 div_ge_s;
   logic [2*WIDTH-1:0]   step_s;
`ifdef ALU_SIGNED_MD_EN
   logic                 neg_r, rneg_r, neg_s, rneg_s;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && ALUOperation == OP_MULT) begin
               state_s = MUL;
            end else if (accept_s && ALUOperation == OP_DIV) begin
               state_s = DIV;
            end else begin
               state_s = IDLE;
            end
         end
         MUL, DIV: begin
            if (last_s) begin
               state_s = IDLE;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_r == IDLE);
      accept_s = in_valid && (state_r == IDLE);
      last_s   = (state_r != IDLE) && (cnt_r == CNT_ONE);
   end

   // Single-cycle result
   always_comb begin
      res_s = {WIDTH{1'b0}};
      case (ALUOperation)
         OP_AND:  res_s = A & B;
         OP_OR:   res_s = A | B;
         OP_NOR:  res_s = ~(A | B);
         OP_ADD:  res_s = A + B;
         OP_SUB:  res_s = A - B;
         OP_BEQ:  res_s = A - B;
         OP_SLL:  res_s = B << Shamt;
         OP_SRL:  res_s = B >> Shamt;
         OP_LUI:  res_s = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_JR:   res_s = A;
         OP_MFHI: res_s = hi;
         OP_MFLO: res_s = lo;
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

   // Operand magnitudes (and result signs) captured when MULT/DIV is accepted
   always_comb begin
`ifdef ALU_SIGNED_MD_EN
      a_mag_s = A[WIDTH-1] ? -A : A;
      b_mag_s = B[WIDTH-1] ? -B : B;
      neg_s   = A[WIDTH-1] ^ B[WIDTH-1];
      rneg_s  = A[WIDTH-1];
`else
      a_mag_s = A;
      b_mag_s = B;
`endif
   end

   // One iteration: shift-add for MUL, restoring shift-subtract for DIV; acc_r = {upper, lower}
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? mcand_r : {WIDTH{1'b0}})};
      div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
      div_sub_s   = div_shift_s[WIDTH-1:0] - mcand_r;
      if (state_r == MUL) begin
         step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else if (div_ge_s) begin
         step_s = {div_sub_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
         step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign fix-up at completion; a zero divisor naturally leaves the dividend as remainder
   always_comb begin
`ifdef ALU_SIGNED_MD_EN
      if (state_r == MUL) begin
         {fin_hi_s, fin_q_s} = neg_r ? -step_s : step_s;
      end else begin
         fin_hi_s = rneg_r ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
         fin_q_s  = neg_r ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
      end
`else
      {fin_hi_s, fin_q_s} = step_s;
`endif
      fin_lo_s = (state_r == DIV && bz_r) ? {WIDTH{1'b1}} : fin_q_s;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r       <= {(SHAMT_W+1){1'b0}};
         mcand_r     <= {WIDTH{1'b0}};
         acc_r       <= {(2*WIDTH){1'b0}};
         bz_r        <= 1'b0;
         out_valid   <= 1'b0;
         ALUResult   <= {WIDTH{1'b0}};
         Zero        <= 1'b1;
         div_by_zero <= 1'b0;
         hi          <= {WIDTH{1'b0}};
         lo          <= {WIDTH{1'b0}};
`ifdef ALU_SIGNED_MD_EN
         neg_r       <= 1'b0;
         rneg_r      <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         if (accept_s) begin
            if (ALUOperation == OP_MULT || ALUOperation == OP_DIV) begin
               cnt_r   <= CNT_INIT;
               mcand_r <= (ALUOperation == OP_MULT) ? a_mag_s : b_mag_s;
               acc_r   <= {{WIDTH{1'b0}}, ((ALUOperation == OP_MULT) ? b_mag_s : a_mag_s)};
               bz_r    <= (B == {WIDTH{1'b0}});
`ifdef ALU_SIGNED_MD_EN
               neg_r   <= neg_s;
               rneg_r  <= rneg_s;
`endif
            end else begin
               ALUResult   <= res_s;
               Zero        <= (res_s == {WIDTH{1'b0}});
               out_valid   <= 1'b1;
               div_by_zero <= 1'b0;
            end
         end else if (state_r != IDLE) begin
            acc_r <= step_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (last_s) begin
               hi          <= fin_hi_s;
               lo          <= fin_lo_s;
               ALUResult   <= fin_lo_s;
               Zero        <= (fin_lo_s == {WIDTH{1'b0}});
               out_valid   <= 1'b1;
               div_by_zero <= (state_r == DIV) && bz_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations queued at issue, checked on each out_valid pulse.
module tb_alu_multicycle;

   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_MFHI = 4'b0101;
   localparam logic [3:0] OP_MFLO = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_MULT = 4'b1101;
   localparam logic [3:0] OP_LUI  = 4'b1110;
   localparam logic [3:0] OP_DIV  = 4'b1111;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        dbz;
      logic [31:0] hi;
      logic [31:0] lo;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALUOperation;
   logic [31:0] A, B;
   logic [4:0]  Shamt;
   logic        out_valid;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        div_by_zero;
   logic [31:0] hi, lo;

   exp_t        sbq[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOperation(ALUOperation), .A(A), .B(B), .Shamt(Shamt),
      .out_valid(out_valid), .ALUResult(ALUResult), .Zero(Zero),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh);
      exp_t        e;
      logic [63:0] up;
      longint      pa, pb, pp;
      int          sa, sb;
      e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.lat = 1; e.acc = 0;
      case (op)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = ~(a | b);
         4'b0011: e.res = a + b;
         4'b0100, 4'b1100: e.res = a - b;
         4'b1000: e.res = b << sh;
         4'b1001: e.res = b >> sh;
         4'b1110: e.res = {b[15:0], 16'h0000};
         4'b1011: e.res = a;
         4'b0101: e.res = m_hi;
         4'b0110: e.res = m_lo;
         4'b1101: begin
`ifdef ALU_SIGNED_MD_EN
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            pp = pa * pb;
            {e.hi, e.lo} = pp;
`else
            up = {32'd0, a} * {32'd0, b};
            {e.hi, e.lo} = up;
`endif
            e.res = e.lo; e.lat = 33;
         end
         4'b1111: begin
            if (b == 32'd0) begin
               e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
            end else begin
`ifdef ALU_SIGNED_MD_EN
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  e.lo = a; e.hi = 32'd0;
               end else begin
                  sa = $signed(a); sb = $signed(b);
                  e.lo = sa / sb; e.hi = sa % sb;
               end
`else
               e.lo = a / b; e.hi = a % b;
`endif
            end
            e.res = e.lo; e.lat = 33;
         end
         default: e.res = 32'd0;
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   // Called at a negedge; holds the request until in_ready, then releases after the accepting edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
      exp_t e;
      int   g;
      ALUOperation = op; A = a; B = b; Shamt = sh; in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      check_eq("accept_wait", 32'(in_ready), 32'd1);
      e = model(op, a, b, sh);
      e.acc = cyc;
      if (op == OP_MULT || op == OP_DIV) begin
         m_hi = e.hi; m_lo = e.lo;
      end
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((sbq.size() != 0 || !in_ready) && g < 200) begin
         @(negedge clk);
         g++;
      end
      check_eq("drain", 32'(sbq.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (sbq.size() == 0) begin
            check_eq("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            e = sbq.pop_front();
            check_eq("result", ALUResult, e.res);
            check_eq("zero", 32'(Zero), 32'(e.zero));
            check_eq("dbz", 32'(div_by_zero), 32'(e.dbz));
            check_eq("hi", hi, e.hi);
            check_eq("lo", lo, e.lo);
            check_eq("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; ALUOperation = 4'd0; A = 32'd0; B = 32'd0; Shamt = 5'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_result", ALUResult, 32'd0);
      check_eq("rst_zero", 32'(Zero), 32'd1);
      check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
      check_eq("rst_hi", hi, 32'd0);
      check_eq("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
      issue(OP_SUB, 32'd5, 32'd5, 5'd0);
      issue(OP_LUI, 32'd0, 32'h0000_1234, 5'd0);
      wait_idle();
      check_eq("lui_result", ALUResult, 32'h1234_0000);

      // MFHI is held while the MULT is busy and must be taken only afterwards
      issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 5'd0);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
      wait_idle();
      check_eq("mult_hi", hi, 32'd1);
      check_eq("mult_lo", lo, 32'd0);
      check_eq("mfhi_result", ALUResult, 32'd1);

      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
      wait_idle();
`ifdef ALU_SIGNED_MD_EN
      check_eq("smul_hi", hi, 32'hFFFF_FFFF);
      check_eq("smul_lo", lo, 32'hFFFF_FFEB);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
      wait_idle();
      check_eq("sdiv_lo", lo, 32'hFFFF_FFFD);
      check_eq("sdiv_hi", hi, 32'hFFFF_FFFF);
`else
      issue(OP_DIV, 32'd7, 32'd2, 5'd0);
      wait_idle();
      check_eq("udiv_lo", lo, 32'd3);
      check_eq("udiv_hi", hi, 32'd1);
`endif
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
      issue(OP_MFLO, 32'd0, 32'd0, 5'd0);

      issue(OP_DIV, 32'd100, 32'd0, 5'd0);
      wait_idle();
      check_eq("dz_lo", lo, 32'hFFFF_FFFF);
      check_eq("dz_hi", hi, 32'd100);
      check_eq("dz_flag", 32'(div_by_zero), 32'd1);
      issue(OP_ADD, 32'd1, 32'd1, 5'd0);
      wait_idle();
      check_eq("dz_clear", 32'(div_by_zero), 32'd0);
      check_eq("add_result", ALUResult, 32'd2);

      issue(OP_SLL, 32'd0, 32'd1, 5'd31);
      issue(OP_SRL, 32'd0, 32'h8000_0000, 5'd31);
      issue(4'b0111, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
      wait_idle();
      check_eq("undef_zero", 32'(Zero), 32'd1);

      for (int i = 0; i < 30; i++) begin
         issue(4'($urandom_range(0, 15)), $urandom,
               ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom, 5'($urandom_range(0, 31)));
      end
      wait_idle();

      // Reset in the middle of a MULT: the operation must vanish without a pulse
      ALUOperation = OP_MULT; A = 32'd7; B = 32'd9; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check_eq("busy_before_rst", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_hi", hi, 32'd0);
      check_eq("mid_rst_lo", lo, 32'd0);
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_zero", 32'(Zero), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (40) @(negedge clk);
      issue(OP_MFHI, 32'd0, 32'd0, 5'd0);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the single-cycle datapath ALU. It keeps the core logic, arithmetic, shift, LUI and JR operations and registers their results. It adds an iterative multiply/divide unit with HI/LO registers and a valid/ready handshake. It sits in the EX stage and stalls the pipeline through `in_ready` while a multiply or divide is in flight.

## Interface
- `WIDTH`, 32: datapath width; even, ≥ 8.
- `SHAMT_W`, 5: shift-amount width; must equal $clog2(WIDTH).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request; accepted on a rising edge while `in_ready`=1.
- `in_ready`  out  1  unit idle, able to accept.
- `ALUOperation`  in  4  opcode, sampled on acceptance.
- `A`, `B`  in  WIDTH  operands, sampled on acceptance.
- `Shamt`  in  SHAMT_W  shift amount, sampled on acceptance.
- `out_valid`  out  1  one-cycle pulse: `ALUResult`/`Zero` are new.
- `ALUResult`  out  WIDTH  registered result; holds its value between pulses.
- `Zero`  out  1  registered, equals (`ALUResult`==0).
- `div_by_zero`  out  1  registered, set with the result of a DIV whose B==0; cleared by any later result.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 NOR
  - 0011 ADD (wraps mod 2^WIDTH)
  - 0100 SUB
  - 1100 BEQ (A−B)
  - 1000 SLL: B<<Shamt
  - 1001 SRL: B>>Shamt (logical)
  - 1110 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}
  - 1011 JR: A
  - 0101 MFHI: `hi`
  - 0110 MFLO: `lo`
  - 1101 MULT
  - 1111 DIV
  - Any other opcode: result 0.
- FSM states: IDLE, MUL, DIV. `in_ready` = (state==IDLE).
- IDLE, single-cycle opcode accepted: `ALUResult`, `Zero` and `out_valid`=1 are registered on the accepting edge. The FSM stays in IDLE, so back-to-back accepts give one result per cycle.
- IDLE, MULT accepted: latch operand magnitudes and sign, clear the accumulator, load a counter with WIDTH, go to MUL.
  - MUL: radix-2 shift-add, one multiplier bit per edge.
- IDLE, DIV accepted: same latching, go to DIV.
  - DIV: restoring shift-subtract, one quotient bit per edge.
- Final iteration edge (counter hits 0):
  - MULT: {`hi`,`lo`} = 2·WIDTH-bit product.
  - DIV: `lo` = quotient, `hi` = remainder; remainder takes the sign of A; truncation toward zero.
  - `ALUResult` = new `lo`, `Zero`, `out_valid`=1, return to IDLE.
- DIV with B==0: still runs WIDTH cycles. Result: `lo` = all ones, `hi` = A, `div_by_zero`=1.
- MFHI/MFLO accepted on the edge after a MULT/DIV completes return the new HI/LO values.
- `in_valid` while `in_ready`=0: ignored; the requester must hold the request.
- `hi`/`lo` change only at MULT/DIV completion.

## Timing
- Reset (asynchronous, any time, including mid-MUL/DIV): state IDLE, counter 0, `ALUResult`=0, `Zero`=1, `out_valid`=0, `div_by_zero`=0, `hi`=`lo`=0, `in_ready`=1. An in-flight operation is discarded and produces no `out_valid`.
- Single-cycle ops: result visible 1 cycle after the accepting edge.
- MULT/DIV:
  - Accept at edge k; `in_ready`=0 from edge k; iterations at edges k+1..k+WIDTH.
  - `out_valid` pulse and `in_ready`=1 after edge k+WIDTH, so latency is WIDTH+1 cycles.
  - Earliest next accept is edge k+WIDTH+1.
- `out_valid` is never high for two consecutive cycles from one op. Consecutive single-cycle accepts give consecutive pulses.

## Configuration
- `ALU_SIGNED_MD_EN` defined:
  - MULT/DIV are two's-complement signed.
  - Operands are converted to magnitudes at acceptance and the sign is fixed at completion.
  - Most-negative ÷ −1 yields `lo` = most-negative and `hi`=0.
- Not defined: MULT/DIV are unsigned, with no sign logic. Timing is identical.

## Test plan
- Reset mid-MULT (WIDTH=32, accept MULT A=7 B=9, assert `reset` low at cycle 10) -> no `out_valid`; `hi`=`lo`=0; `in_ready`=1 immediately.
- ADD 0xFFFFFFFF+1, then SUB 5−5, then LUI B=0x1234, accepted back-to-back -> three consecutive pulses:
  - 0x00000000 with Zero=1
  - 0 with Zero=1
  - 0x12340000 with Zero=0
- MULT 0x0001_0000 × 0x0001_0000 -> `out_valid` exactly 33 cycles after accept; `hi`=1, `lo`=0, `ALUResult`=0, Zero=1; `in_valid` held during busy is not accepted.
- Signed (macro on): MULT −3×7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7÷2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Unsigned (macro off): DIV 7÷2 -> `lo`=3, `hi`=1.
- DIV 100÷0 -> after 33 cycles `lo`=0xFFFFFFFF, `hi`=100, `div_by_zero`=1. Next ADD 1+1 -> `div_by_zero`=0, result 2.
- SLL B=1 Shamt=31 -> 0x80000000; SRL B=0x80000000 Shamt=31 -> 1. MFHI on the edge after a MULT completes -> the new `hi`. Opcode 0111 -> result 0, Zero=1.
